wfg_dds_multi: RTL
==================

// Module: wfg_dds_multi
// PURPOSE
//  Parametrised multi-channel DDS waveform generator. Successor to the single-channel WFG_DDS_FS.
//  Each channel has its own tuning word, phase offset, waveform mode, duty and amplitude shift.
//  Settings are double-buffered and commit glitch-free at the channel's period wrap or on preset.
//  Sits between the clock divider/ring-oscillator clock domain and the DAC/VGA sample consumers.
// PARAMETERS
//  N_CH   2   number of independent channels (1..8)
//  ACC_W  16  phase accumulator / tuning word / phase offset width
//  OUT_W  8   sample width per channel (OUT_W <= ACC_W, OUT_W >= 4)
// PORTS
//  clk        in   1            system clock
//  rst        in   1            asynchronous active-high reset
//  en         in   1            1 = accumulators advance; 0 = accumulators and pipeline hold
//  preset     in   1            synchronous phase-align: commit all shadows, acc <= 0
//  ld         in   1            write shadow registers of channel ld_ch this cycle
//  ld_ch      in   clog2(N_CH)  channel select for ld (max(1,...) bits)
//  tw         in   ACC_W        tuning word (phase increment per enabled cycle)
//  phase_off  in   ACC_W        phase offset added before shaping
//  mode       in   3            0 ramp, 1 inverted ramp, 2 triangle, 3 square, 4-7 DC mid-scale
//  duty       in   OUT_W        square threshold
//  amp_shift  in   2            attenuation: right-shift 0..3, re-centred
//  wave       out  N_CH*OUT_W   samples; channel k at [k*OUT_W +: OUT_W]
//  wave_valid out  1            pipeline holds valid samples
//  sync       out  N_CH         1-cycle pulse marking the first sample of a new period, per channel
// BEHAVIOUR
//  Reset (async): acc, active and shadow tw/off/mode/amp = 0; duty = 2^(OUT_W-1);
//   wave = 0, wave_valid = 0, sync = 0. tw = 0 means no wrap, so the first config needs preset.
//  ld: on a clk edge with ld=1, shadow[ld_ch] <= {tw,phase_off,mode,duty,amp_shift}.
//   ld_ch >= N_CH: ignored.
//  Accumulator (en=1): acc <= acc + tw_act (mod 2^ACC_W). wrap = carry out of that add.
//   On wrap, active <= shadow (shadow value as of before this edge).
//   An ld in the same cycle lands in shadow and commits at the next wrap.
//  preset=1 (overrides en): every acc <= 0; every active <= shadow, including an ld written
//   the same cycle (bypass). Pipeline flushed: wave_valid <= 0, sync <= 0.
//  en=0: acc, pipeline, wave and sync hold; sync forced 0; ld still writes shadows.
//  Pipeline, 2 stages, latency 2 enabled cycles from acc to wave:
//   S1: p = acc + off_act (mod 2^ACC_W); x = p[ACC_W-1 -: OUT_W]; m = x[OUT_W-1];
//       ramp: y = x; inv: y = ~x; tri: t = {x[OUT_W-2:0],1'b0}, y = m ? ~t : t;
//       square: y = (x < duty) ? all-ones : 0; DC: y = 2^(OUT_W-1).
//   S2: wave_k = (y >> a) + ((2^OUT_W - 2^(OUT_W-a)) >> 1), a = amp_act. Fits OUT_W, no saturation.
//  mode/duty/amp used by S1/S2 are the active values sampled with the same acc (no mixing).
//  wave_valid: 0 after reset/preset; 1 after 2 enabled cycles; stays 1 until reset/preset.
//  sync[k]: wrap of channel k delayed through the pipeline, so it coincides with the
//   first wave sample of the new period. Not asserted while wave_valid = 0.
//  Reset mid-operation: all state clears immediately; active tw returns to 0.
// TESTING
//  1 rst; ld ch0 tw=0x0100 mode=0; preset; en=1 -> wave[7:0] = 0,1,2,... from 2nd cycle after
//    preset; wave_valid rises at the same cycle; sync[0] every 256 cycles on the sample 0.
//  2 ch1 same tw, phase_off=0x8000; preset -> wave ch1 == (ch0 + 128) mod 256 every cycle.
//  3 ch0 mode=2 tw=0x0200 -> 0,4,...,252,255,251,...,3, then repeats; period 128 cycles.
//  4 Running ramp tw=0x0100; ld tw=0x0400 at acc=0x4000 -> step 1 continues to 255,
//    then sync, then step 4 (0,4,8,...).
//  5 mode=3 duty=64 amp_shift=1 tw=0x0100 -> 64 samples of 191 then 192 samples of 64.
//  6 rst pulse mid-stream (between edges) -> wave=0, wave_valid=0, sync=0 immediately;
//    after release with no preset, acc stays 0.

Source files
------------

// File: rtl/wfg_dds_multi.sv
// Multi-channel DDS waveform generator.
// Each channel has a phase accumulator and per-channel settings (tuning word,
// phase offset, waveform mode, square duty, amplitude shift). Settings are
// written into a shadow copy and become active when the channel's accumulator
// wraps, or on preset.
// A two-stage pipeline follows the accumulator:
//   S1 applies the phase offset and shapes the waveform.
//   S2 applies attenuation and re-centres the result.
// A per-channel sync pulse is aligned with the first sample of each new period.
module wfg_dds_multi #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned OUT_W = 8,
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   preset,
  input  logic                   ld,
  input  logic [CH_W-1:0]        ld_ch,
  input  logic [ACC_W-1:0]       tw,
  input  logic [ACC_W-1:0]       phase_off,
  input  logic [2:0]             mode,
  input  logic [OUT_W-1:0]       duty,
  input  logic [1:0]             amp_shift,
  output logic [N_CH*OUT_W-1:0]  wave,
  output logic                   wave_valid,
  output logic [N_CH-1:0]        sync
);

  typedef enum logic [2:0] {
    MODE_RAMP = 3'd0,
    MODE_INV  = 3'd1,
    MODE_TRI  = 3'd2,
    MODE_SQR  = 3'd3
  } wave_mode_e;

  // Offset that re-centres an attenuated sample:
  // (2^OUT_W - 2^(OUT_W-a)) / 2
  function automatic logic [OUT_W-1:0] centre(input logic [1:0] a);
    logic [OUT_W:0] full;
    logic [OUT_W:0] part;
    full         = '0;
    full[OUT_W]  = 1'b1;
    part         = full >> a;
    return OUT_W'((full - part) >> 1);
  endfunction

  // Pipeline occupancy. Shared by all channels because they advance in lockstep.
  logic v1_q;
  logic v2_q;

  // Track how many enabled cycles have passed since reset or preset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else if (preset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else if (en) begin
      v1_q <= 1'b1;
      v2_q <= v1_q;
    end
  end

  assign wave_valid = v2_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    // Shadow settings: written by ld.
    logic [ACC_W-1:0] sh_tw_q;
    logic [ACC_W-1:0] sh_off_q;
    logic [2:0]       sh_mode_q;
    logic [OUT_W-1:0] sh_duty_q;
    logic [1:0]       sh_amp_q;

    // Active settings: used by the accumulator and S1.
    logic [ACC_W-1:0] ac_tw_q;
    logic [ACC_W-1:0] ac_off_q;
    logic [2:0]       ac_mode_q;
    logic [OUT_W-1:0] ac_duty_q;
    logic [1:0]       ac_amp_q;

    // Accumulator state. wrap_q marks that the current acc value came from a wrap.
    logic [ACC_W-1:0] acc_q;
    logic             wrap_q;

    // S1 and S2 registers.
    logic [OUT_W-1:0] y_q;
    logic [1:0]       s1_amp_q;
    logic             s1_sync_q;
    logic [OUT_W-1:0] wave_q;
    logic             sync_q;

    // Combinational next-state and datapath values.
    logic             ld_hit;
    logic [ACC_W:0]   acc_d;
    logic [ACC_W-1:0] p_d;
    logic [OUT_W-1:0] x_d;
    logic [OUT_W-1:0] t_d;
    logic [OUT_W-1:0] y_d;
    logic [OUT_W-1:0] wave_d;

    // Bypass values: what the shadow holds after this edge, so a preset
    // commits an ld that arrives in the same cycle.
    logic [ACC_W-1:0] nx_tw;
    logic [ACC_W-1:0] nx_off;
    logic [2:0]       nx_mode;
    logic [OUT_W-1:0] nx_duty;
    logic [1:0]       nx_amp;

    assign ld_hit = ld && (ld_ch == CH_W'(g));

    // Accumulator add, phase offset, waveform shaping, attenuation, and shadow bypass.
    always_comb begin
      acc_d  = {1'b0, acc_q} + {1'b0, ac_tw_q};
      p_d    = acc_q + ac_off_q;
      x_d    = OUT_W'(p_d >> (ACC_W - OUT_W));
      t_d    = {x_d[OUT_W-2:0], 1'b0};
      y_d    = '0;

      case (ac_mode_q)
        MODE_RAMP: y_d = x_d;
        MODE_INV:  y_d = ~x_d;
        MODE_TRI:  y_d = x_d[OUT_W-1] ? ~t_d : t_d;
        MODE_SQR:  y_d = (x_d < ac_duty_q) ? '1 : '0;
        default:   y_d[OUT_W-1] = 1'b1;
      endcase

      wave_d  = (y_q >> s1_amp_q) + centre(s1_amp_q);

      nx_tw   = ld_hit ? tw        : sh_tw_q;
      nx_off  = ld_hit ? phase_off : sh_off_q;
      nx_mode = ld_hit ? mode      : sh_mode_q;
      nx_duty = ld_hit ? duty      : sh_duty_q;
      nx_amp  = ld_hit ? amp_shift : sh_amp_q;
    end

    // Shadow load, active commit, accumulator advance, and the two pipeline stages.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sh_tw_q   <= '0;
        sh_off_q  <= '0;
        sh_mode_q <= '0;
        sh_duty_q <= {1'b1, {(OUT_W-1){1'b0}}};
        sh_amp_q  <= '0;

        ac_tw_q   <= '0;
        ac_off_q  <= '0;
        ac_mode_q <= '0;
        ac_duty_q <= {1'b1, {(OUT_W-1){1'b0}}};
        ac_amp_q  <= '0;

        acc_q     <= '0;
        wrap_q    <= 1'b0;

        y_q       <= '0;
        s1_amp_q  <= '0;
        s1_sync_q <= 1'b0;
        wave_q    <= '0;
        sync_q    <= 1'b0;
      end else begin
        if (ld_hit) begin
          sh_tw_q   <= tw;
          sh_off_q  <= phase_off;
          sh_mode_q <= mode;
          sh_duty_q <= duty;
          sh_amp_q  <= amp_shift;
        end

        if (preset) begin
          ac_tw_q   <= nx_tw;
          ac_off_q  <= nx_off;
          ac_mode_q <= nx_mode;
          ac_duty_q <= nx_duty;
          ac_amp_q  <= nx_amp;

          acc_q     <= '0;
          wrap_q    <= 1'b0;
          s1_sync_q <= 1'b0;
          sync_q    <= 1'b0;
        end else if (en) begin
          acc_q  <= acc_d[ACC_W-1:0];
          wrap_q <= acc_d[ACC_W];

          // A wrap commits the shadow as it was before this edge, so the new
          // settings start with the first sample of the new period.
          if (acc_d[ACC_W]) begin
            ac_tw_q   <= sh_tw_q;
            ac_off_q  <= sh_off_q;
            ac_mode_q <= sh_mode_q;
            ac_duty_q <= sh_duty_q;
            ac_amp_q  <= sh_amp_q;
          end

          y_q       <= y_d;
          s1_amp_q  <= ac_amp_q;
          s1_sync_q <= wrap_q;
          wave_q    <= wave_d;
          sync_q    <= s1_sync_q & v1_q;
        end else begin
          sync_q <= 1'b0;
        end
      end
    end

    assign wave[g*OUT_W +: OUT_W] = wave_q;
    assign sync[g]                = sync_q;
  end

endmodule
